// File: rtl/bmf_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// bmf_stream_decoder_if
// Handshake bundle for the BMF stream decoder. It groups three streams.
//   cfg : cfg_valid/cfg_ready/cfg_data/cfg_last carry basis rows of H.
//   in  : in_valid/in_ready/in_k carry the latent codes.
//   out : out_valid/out_ready/out_po carry the reconstructed vectors.
// The master modport is the producer/consumer side (upstream compressor plus
// downstream evaluator). The slave modport is the decoder itself.
// Parameters K (latent width) and M (output width) must match the decoder.
// ---------------------------------------------------------------------------
interface bmf_stream_decoder_if #(
  parameter int K = 5,
  parameter int M = 7
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [M-1:0] cfg_data;
  logic         cfg_last;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_k;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_po;

  modport master (
    output cfg_valid, cfg_data, cfg_last, in_valid, in_k, out_ready,
    input  cfg_ready, in_ready, out_valid, out_po
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, in_valid, in_k, out_ready,
    output cfg_ready, in_ready, out_valid, out_po
  );
endinterface

// File: rtl/bmf_stream_decoder.sv
// ---------------------------------------------------------------------------
// bmf_stream_decoder
// This is the decompressor half of a Boolean-matrix-factorised approximate
// circuit. It holds a K x M basis matrix H, which is loaded one row at a time.
// Each K-bit latent code k becomes the M-bit vector
//   out[j] = reduce_i (k[i] & H[i][j]).
// The reduction is OR when SEMIRING=0 and XOR when SEMIRING=1.
// Ports:
//   clk, rst  : clock and synchronous active-high reset.
//   bus       : cfg/in/out handshakes (slave side of bmf_stream_decoder_if).
//   loaded    : a complete H is resident and codes are being accepted.
//   cfg_err   : sticky flag. cfg_last was not seen exactly on row K-1.
//   dec_count : count of vectors accepted on the out stream since the last
//               reset or reload. It wraps at 2^CNT_W.
// ---------------------------------------------------------------------------
module bmf_stream_decoder #(
  parameter int K        = 5,
  parameter int M        = 7,
  parameter int SEMIRING = 0,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bmf_stream_decoder_if.slave  bus,
  output logic                 loaded,
  output logic                 cfg_err,
  output logic [CNT_W-1:0]     dec_count
);
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(K - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_e;

  state_e             state_q, state_d;
  logic [M-1:0]       h_q [K];
  logic [M-1:0]       h_d [K];
  logic [RW-1:0]      row_q, row_d;
  logic               out_valid_q, out_valid_d;
  logic [M-1:0]       out_po_q, out_po_d;
  logic               loaded_q, loaded_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   dec_count_q, dec_count_d;

  logic               cfg_ready;
  logic               in_ready;
  logic               cfg_xfer;
  logic               in_xfer;
  logic               out_xfer;
  logic [RW-1:0]      wr_row;
  logic [M-1:0]       decoded;

  // Ready generation.
  // While H is being filled, only cfg rows are accepted.
  // In RUN, a reload may start only once the output register is empty.
  // If a reload and a code arrive together, the reload takes priority.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      EMPTY, LOAD: cfg_ready = 1'b1;
      RUN: begin
        cfg_ready = !out_valid_q;
        in_ready  = out_valid_q ? bus.out_ready : !bus.cfg_valid;
      end
      default: ;
    endcase
  end

  assign cfg_xfer = bus.cfg_valid && cfg_ready;
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  // Matrix-vector product over the selected semiring.
  // A row that was never written reads as zero.
  always_comb begin
    decoded = '0;
    for (int i = 0; i < K; i++) begin
      if (bus.in_k[i]) begin
        decoded = (SEMIRING != 0) ? (decoded ^ h_q[i]) : (decoded | h_q[i]);
      end
    end
  end

  // Next-state logic.
  // The first row of every load clears the whole matrix. As a result, rows
  // skipped by an early cfg_last are zero and do not hold data from an
  // older basis.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_po_d    = out_po_q;
    loaded_d    = loaded_q;
    cfg_err_d   = cfg_err_q;
    dec_count_d = dec_count_q;
    wr_row      = (state_q == LOAD) ? row_q : '0;

    if (cfg_xfer) begin
      if (wr_row == '0) begin
        for (int r = 0; r < K; r++) h_d[r] = '0;
        dec_count_d = '0;
      end
      h_d[wr_row] = bus.cfg_data;
      if ((wr_row == LAST_ROW) || bus.cfg_last) begin
        state_d  = RUN;
        loaded_d = 1'b1;
        row_d    = '0;
        if ((wr_row != LAST_ROW) || !bus.cfg_last) cfg_err_d = 1'b1;
      end else begin
        state_d  = LOAD;
        loaded_d = 1'b0;
        row_d    = RW'(wr_row + 1'b1);
      end
    end

    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_po_d    = decoded;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (out_xfer) dec_count_d = dec_count_q + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      h_q         <= '{default: '0};
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_po_q    <= '0;
      loaded_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      dec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_po_q    <= out_po_d;
      loaded_q    <= loaded_d;
      cfg_err_q   <= cfg_err_d;
      dec_count_q <= dec_count_d;
    end
  end

  // out_valid is masked during reset so that a held vector cannot be handed
  // over in the cycle that discards it.
  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q && !rst;
  assign bus.out_po    = out_po_q;
  assign loaded        = loaded_q;
  assign cfg_err       = cfg_err_q;
  assign dec_count     = dec_count_q;
endmodule

// File: tb/tb_bmf_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_bmf_stream_decoder
// Two decoders receive identical stimulus.
//   dut_a uses OR reduction with a 16-bit counter.
//   dut_b uses XOR reduction with a 4-bit counter.
// A reference copy of H predicts both reductions whenever a code is accepted.
// The predictions are queued and then compared when each vector leaves.
// ---------------------------------------------------------------------------
module tb_bmf_stream_decoder;
  localparam int K = 5;
  localparam int M = 7;

  typedef logic [M-1:0] basis_t [K];
  typedef struct packed {
    logic [M-1:0] po_or;
    logic [M-1:0] po_xor;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_last, in_valid, out_ready;
  logic [M-1:0] cfg_data;
  logic [K-1:0] in_k;

  logic loaded_a, cfg_err_a, loaded_b, cfg_err_b;
  logic [15:0] dec_count_a;
  logic [3:0]  dec_count_b;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_count = 0;
  int count_base = 0;
  int cycle = 0;
  bit prev_in_xfer = 1'b0;
  exp_t sb[$];
  exp_t popped;
  logic [M-1:0] model_h [K];

  bmf_stream_decoder_if #(.K(K), .M(M)) bus_a ();
  bmf_stream_decoder_if #(.K(K), .M(M)) bus_b ();

  assign bus_a.cfg_valid = cfg_valid;
  assign bus_a.cfg_data  = cfg_data;
  assign bus_a.cfg_last  = cfg_last;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_k      = in_k;
  assign bus_a.out_ready = out_ready;
  assign bus_b.cfg_valid = cfg_valid;
  assign bus_b.cfg_data  = cfg_data;
  assign bus_b.cfg_last  = cfg_last;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_k      = in_k;
  assign bus_b.out_ready = out_ready;

  bmf_stream_decoder #(.K(K), .M(M), .SEMIRING(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .loaded(loaded_a), .cfg_err(cfg_err_a), .dec_count(dec_count_a)
  );

  bmf_stream_decoder #(.K(K), .M(M), .SEMIRING(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .loaded(loaded_b), .cfg_err(cfg_err_b), .dec_count(dec_count_b)
  );

  // Free-running clock and a cycle counter used for throughput checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Safety net so the run always terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference matrix-vector product for either semiring.
  function automatic logic [M-1:0] modelReduce(input logic [K-1:0] k, input bit use_xor);
    logic [M-1:0] acc;
    acc = '0;
    for (int i = 0; i < K; i++) begin
      if (k[i]) acc = use_xor ? (acc ^ model_h[i]) : (acc | model_h[i]);
    end
    return acc;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  // It checks that a vector appears exactly one cycle after each accepted
  // code. It pops and compares vectors as they leave, and it pushes a
  // prediction for the code about to be accepted.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_in_xfer = 1'b0;
      exp_count = 0;
    end else begin
      if (prev_in_xfer) checkOutput("latency_out_valid", 32'(bus_a.out_valid), 32'd1);
      if (bus_a.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 32'd1, 32'd0);
        end else begin
          popped = sb.pop_front();
          checkOutput("out_po_or", 32'(bus_a.out_po), 32'(popped.po_or));
          checkOutput("out_po_xor", 32'(bus_b.out_po), 32'(popped.po_xor));
        end
        exp_count++;
      end
      prev_in_xfer = in_valid && bus_a.in_ready;
      if (prev_in_xfer) sb.push_back('{modelReduce(in_k, 1'b0), modelReduce(in_k, 1'b1)});
    end
  end

  // Waits for ready with a bounded number of cycles, then steps past the
  // edge on which the transfer happens.
  task automatic waitReady(input bit is_cfg, input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (is_cfg ? bus_a.cfg_ready : bus_a.in_ready) begin
        if (is_cfg && in_valid) checkOutput("cfg_wins_in_ready", 32'(bus_a.in_ready), 32'd0);
        break;
      end
      n++;
      if (n >= 60) begin
        checkOutput(tag, 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offers one latent code and leaves in_valid asserted. The caller drops
  // it, so consecutive calls stream back to back.
  task automatic applyStimulus(input logic [K-1:0] k);
    in_valid = 1'b1;
    in_k = k;
    waitReady(1'b0, "in_ready_timeout");
  endtask

  // Sends rows 0..last_row, with cfg_last on the final row when mark_last
  // is set. It also updates the reference copy of H.
  task automatic loadBasis(input basis_t rows, input int last_row, input bit mark_last);
    for (int r = 0; r < K; r++) model_h[r] = (r <= last_row) ? rows[r] : '0;
    for (int r = 0; r <= last_row; r++) begin
      cfg_valid = 1'b1;
      cfg_data = rows[r];
      cfg_last = mark_last && (r == last_row);
      waitReady(1'b1, "cfg_ready_timeout");
      if (r == 0) count_base = exp_count;
    end
    cfg_valid = 1'b0;
    cfg_last = 1'b0;
  endtask

  // Waits until every predicted vector has left and the output is idle.
  task automatic waitDrain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !bus_a.out_valid) break;
      n++;
      if (n >= 60) begin
        checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkCount(input string tag, input int n);
    checkOutput({tag, "_a"}, 32'(dec_count_a), 32'(n % 65536));
    checkOutput({tag, "_b"}, 32'(dec_count_b), 32'(n % 16));
  endtask

  task automatic doReset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_base = 0;
  endtask

  // Main test sequence.
  initial begin
    basis_t plan_h, xor_h, new_h, early_h;
    int start_cycle;
    logic [K-1:0] c1, c2;

    plan_h  = '{7'b0000101, 7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000};
    xor_h   = '{7'b0000011, 7'b0000010, 7'b0000000, 7'b0000000, 7'b0000000};
    new_h   = '{7'b1010101, 7'b0110011, 7'b0001111, 7'b1111111, 7'b0000000};
    early_h = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b1110000, 7'b1110000};
    for (int r = 0; r < K; r++) model_h[r] = '0;
    cfg_data = '0;
    cfg_last = 1'b0;
    in_k = '0;
    out_ready = 1'b1;
    doReset();

    // Reset state.
    checkOutput("rst_loaded", 32'(loaded_a), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg_err_a), 32'd0);
    checkOutput("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("rst_out_po", 32'(bus_a.out_po), 32'd0);
    checkOutput("rst_cfg_ready", 32'(bus_a.cfg_ready), 32'd1);
    checkOutput("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    checkCount("rst_dec_count", 0);

    // Basic load, followed by three decodes.
    loadBasis(plan_h, K - 1, 1'b1);
    checkOutput("load_loaded", 32'(loaded_a), 32'd1);
    checkOutput("load_cfg_err", 32'(cfg_err_a), 32'd0);
    applyStimulus(5'b00001);
    applyStimulus(5'b11111);
    applyStimulus(5'b00000);
    in_valid = 1'b0;
    waitDrain();
    checkCount("basic_dec_count", 3);

    // Reload with a code already waiting. The code must wait for the new H.
    in_valid = 1'b1;
    in_k = 5'b00011;
    loadBasis(xor_h, K - 1, 1'b1);
    checkCount("reload_dec_count", 0);
    applyStimulus(5'b00011);
    in_valid = 1'b0;
    waitDrain();
    checkCount("xor_dec_count", 1);

    // Back-to-back stream, then backpressure.
    loadBasis(plan_h, K - 1, 1'b1);
    start_cycle = cycle;
    for (int i = 0; i < 8; i++) applyStimulus(K'($urandom));
    in_valid = 1'b0;
    checkOutput("stream_cycles", 32'(cycle - start_cycle), 32'd8);
    waitDrain();
    checkCount("stream_dec_count", 8);
    c1 = 5'b10101;
    c2 = 5'b01010;
    out_ready = 1'b0;
    applyStimulus(c1);
    in_k = c2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_in_ready", 32'(bus_a.in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(bus_a.out_valid), 32'd1);
      checkOutput("hold_po_or", 32'(bus_a.out_po), 32'(modelReduce(c1, 1'b0)));
      checkOutput("hold_po_xor", 32'(bus_b.out_po), 32'(modelReduce(c1, 1'b1)));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(c2);
    in_valid = 1'b0;
    waitDrain();
    checkCount("hold_dec_count", 10);

    // A reload that is blocked until the held vector drains.
    out_ready = 1'b0;
    applyStimulus(5'b00110);
    in_valid = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = new_h[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("busy_cfg_ready", 32'(bus_a.cfg_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    loadBasis(new_h, K - 1, 1'b1);
    checkCount("busy_reload_count", 0);
    applyStimulus(5'b01011);
    applyStimulus(5'b11100);
    in_valid = 1'b0;
    waitDrain();
    checkCount("new_h_count", 2);

    // Early cfg_last on row 2. Rows 3 and 4 must read as zero.
    loadBasis(early_h, 2, 1'b1);
    checkOutput("early_cfg_err", 32'(cfg_err_a), 32'd1);
    checkOutput("early_loaded", 32'(loaded_a), 32'd1);
    applyStimulus(5'b11000);
    applyStimulus(5'b00111);
    applyStimulus(5'b11111);
    in_valid = 1'b0;
    waitDrain();

    // Reset in the middle of a load, then a clean load.
    loadBasis(plan_h, 1, 1'b0);
    checkOutput("partial_loaded", 32'(loaded_a), 32'd0);
    doReset();
    checkOutput("midrst_loaded", 32'(loaded_a), 32'd0);
    checkOutput("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus_a.in_ready), 32'd0);
    checkOutput("midrst_cfg_ready", 32'(bus_a.cfg_ready), 32'd1);
    checkOutput("midrst_cfg_err", 32'(cfg_err_a), 32'd0);
    loadBasis(plan_h, K - 1, 1'b1);
    checkOutput("fresh_loaded", 32'(loaded_a), 32'd1);
    checkOutput("fresh_cfg_err", 32'(cfg_err_a), 32'd0);
    for (int i = 0; i < 17; i++) applyStimulus(K'($urandom));
    in_valid = 1'b0;
    waitDrain();
    checkCount("wrap_dec_count", 17);

    // A full load that never asserts cfg_last still completes, but it
    // raises cfg_err.
    loadBasis(new_h, K - 1, 1'b0);
    checkOutput("nolast_cfg_err", 32'(cfg_err_a), 32'd1);
    checkOutput("nolast_loaded", 32'(loaded_a), 32'd1);
    applyStimulus(5'b10011);
    in_valid = 1'b0;
    waitDrain();
    checkCount("nolast_count", exp_count - count_base);
    checkOutput("nolast_count_one", 32'(dec_count_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
